instruction_fetch: RTL and testbench

//  Bus initiator that reads program words from the 32x32 instruction ROM (5-bit address, active-high

---
 rtl/instruction_fetch.sv | 127 ++++++++++++
 tb/tb_instruction_fetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ROM bus initiator: drives PC and chip select for WAIT_CYCLES, captures the word, hands it to decode via valid/ready.
// Define IFETCH_HALT_ON_WRAP_EN to stop in HALT after the word at the last address is transferred.
module instruction_fetch #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int RESET_PC    = 0,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  load_pc,
    input  logic [ADDR_WIDTH-1:0] load_value,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_cs,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  halted
);

    localparam logic [3:0]            WAIT_LD = 4'(WAIT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] PC_RST  = ADDR_WIDTH'(RESET_PC);
`ifdef IFETCH_HALT_ON_WRAP_EN
    localparam logic [ADDR_WIDTH-1:0] PC_LAST = '1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
`ifdef IFETCH_HALT_ON_WRAP_EN
        , S_HALT = 2'd3
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RST;
            cnt_q   <= 4'd0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        case (state_q)
            S_IDLE: begin
                if (load_pc) pc_d = load_value;
                if (run) begin
                    state_d = S_FETCH;
                    cnt_d   = WAIT_LD;
                end
            end
            S_FETCH: begin
                // A redirect restarts the settle window at the new address.
                if (load_pc) begin
                    pc_d  = load_value;
                    cnt_d = WAIT_LD;
                end else if (cnt_q == 4'd1) begin
                    instr_d = rom_data;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_VALID;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_VALID: begin
                if (load_pc) begin
                    pc_d    = load_value;
                    cnt_d   = WAIT_LD;
                    state_d = run ? S_FETCH : S_IDLE;
                end else if (instr_ready) begin
                    cnt_d   = WAIT_LD;
                    state_d = run ? S_FETCH : S_IDLE;
`ifdef IFETCH_HALT_ON_WRAP_EN
                    if (ipc_q == PC_LAST) state_d = S_HALT;
`endif
                end
            end
`ifdef IFETCH_HALT_ON_WRAP_EN
            S_HALT: begin
                if (load_pc) begin
                    pc_d    = load_value;
                    cnt_d   = WAIT_LD;
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign rom_address = pc_q;
    assign rom_cs      = (state_q == S_FETCH);
    assign instr_valid = (state_q == S_VALID);
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
`ifdef IFETCH_HALT_ON_WRAP_EN
    assign halted      = (state_q == S_HALT);
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        run1, ld1, rdy1, cs1, v1, h1;
    logic [4:0]  lv1, addr1, ipc1;
    logic [31:0] instr1;
    wire  [31:0] rd1;
    logic        run3, ld3, rdy3, cs3, v3, h3;
    logic [4:0]  lv3, addr3, ipc3;
    logic [31:0] instr3;
    wire  [31:0] rd3;

    int n_vec = 0;
    int n_err = 0;
    int xfers1 = 0;
    int xfers3 = 0;
    logic [36:0] exp_q1[$];
    logic [36:0] exp_q3[$];

    function automatic logic [31:0] rom_word(input logic [4:0] a);
        if (a == 5'd0) return 32'hDEADBEEF;
        return {8'hC0, 3'b000, a, 8'h5A, 3'b000, a};
    endfunction

    assign rd1 = cs1 ? rom_word(addr1) : 32'bz;
    assign rd3 = cs3 ? rom_word(addr3) : 32'bz;

    instruction_fetch #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .RESET_PC(0), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset_n(rst_n), .run(run1), .load_pc(ld1), .load_value(lv1),
        .rom_address(addr1), .rom_cs(cs1), .rom_data(rd1), .instr(instr1), .instr_pc(ipc1),
        .instr_valid(v1), .instr_ready(rdy1), .halted(h1)
    );

    instruction_fetch #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .RESET_PC(0), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset_n(rst_n), .run(run3), .load_pc(ld3), .load_value(lv3),
        .rom_address(addr3), .rom_cs(cs3), .rom_data(rd3), .instr(instr3), .instr_pc(ipc3),
        .instr_valid(v3), .instr_ready(rdy3), .halted(h3)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Transfers are decided at the next rising edge; inputs are stable from posedge+2 onward.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("excl1", {63'd0, cs1 & v1}, 64'd0);
            chk("excl3", {63'd0, cs3 & v3}, 64'd0);
            if (v1 && rdy1 && !ld1) begin
                chk("sb1_nonempty", {63'd0, exp_q1.size() != 0}, 64'd1);
                if (exp_q1.size() != 0) begin
                    logic [36:0] e;
                    e = exp_q1.pop_front();
                    chk("sb1_instr", {32'd0, instr1}, {32'd0, e[31:0]});
                    chk("sb1_pc", {59'd0, ipc1}, {59'd0, e[36:32]});
                end
                xfers1++;
            end
            if (v3 && rdy3 && !ld3) begin
                chk("sb3_nonempty", {63'd0, exp_q3.size() != 0}, 64'd1);
                if (exp_q3.size() != 0) begin
                    logic [36:0] e;
                    e = exp_q3.pop_front();
                    chk("sb3_instr", {32'd0, instr3}, {32'd0, e[31:0]});
                    chk("sb3_pc", {59'd0, ipc3}, {59'd0, e[36:32]});
                end
                xfers3++;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        run1 = 0; ld1 = 0; lv1 = '0; rdy1 = 0;
        run3 = 0; ld3 = 0; lv3 = '0; rdy3 = 0;
        #3;
        chk("rst_cs", {63'd0, cs1}, 64'd0);
        chk("rst_valid", {63'd0, v1}, 64'd0);
        chk("rst_halted", {63'd0, h1}, 64'd0);
        chk("rst_instr", {32'd0, instr1}, 64'd0);
        chk("rst_ipc", {59'd0, ipc1}, 64'd0);
        chk("rst_addr", {59'd0, addr1}, 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Start-up with single-cycle settle.
        run1 = 1; rdy1 = 1;
        exp_q1.push_back({5'd0, rom_word(5'd0)});
        exp_q1.push_back({5'd1, rom_word(5'd1)});
        step();
        chk("t1_cs", {63'd0, cs1}, 64'd1);
        chk("t1_addr", {59'd0, addr1}, 64'd0);
        chk("t1_novalid", {63'd0, v1}, 64'd0);
        step();
        chk("t1_valid", {63'd0, v1}, 64'd1);
        chk("t1_instr", {32'd0, instr1}, 64'hDEADBEEF);
        chk("t1_ipc", {59'd0, ipc1}, 64'd0);
        chk("t1_cs_off", {63'd0, cs1}, 64'd0);
        chk("t1_pc", {59'd0, addr1}, 64'd1);
        step();
        chk("t1_valid_1cyc", {63'd0, v1}, 64'd0);
        chk("t1_refetch", {63'd0, cs1}, 64'd1);
        chk("t1_xfers", 64'(xfers1), 64'd1);

        // Backpressure.
        step();
        rdy1 = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", {63'd0, v1}, 64'd1);
            chk("t2_instr", {32'd0, instr1}, {32'd0, rom_word(5'd1)});
            chk("t2_ipc", {59'd0, ipc1}, 64'd1);
            chk("t2_cs", {63'd0, cs1}, 64'd0);
            step();
        end
        rdy1 = 1;
        step();
        chk("t2_xfers", 64'(xfers1), 64'd2);
        chk("t2_addr", {59'd0, addr1}, 64'd2);

        // Redirect while a word is held: the word at 2 is dropped.
        step();
        chk("t3_pre_valid", {63'd0, v1}, 64'd1);
        ld1 = 1; lv1 = 5'h10;
        step();
        ld1 = 0;
        chk("t3_drop", {63'd0, v1}, 64'd0);
        chk("t3_cs", {63'd0, cs1}, 64'd1);
        chk("t3_addr", {59'd0, addr1}, 64'h10);
        chk("t3_noxfer", 64'(xfers1), 64'd2);
        exp_q1.push_back({5'h10, rom_word(5'h10)});
        step();
        chk("t3_ipc", {59'd0, ipc1}, 64'h10);
        run1 = 0;
        step();
        chk("t3_idle_cs", {63'd0, cs1}, 64'd0);
        chk("t3_idle_valid", {63'd0, v1}, 64'd0);
        chk("t3_xfers", 64'(xfers1), 64'd3);
        step();
        chk("t3_idle_cs2", {63'd0, cs1}, 64'd0);

        // Wrap at the top of the address space.
        ld1 = 1; lv1 = 5'd31; run1 = 1;
        exp_q1.push_back({5'd31, rom_word(5'd31)});
`ifndef IFETCH_HALT_ON_WRAP_EN
        exp_q1.push_back({5'd0, rom_word(5'd0)});
        exp_q1.push_back({5'd1, rom_word(5'd1)});
`endif
        step();
        ld1 = 0;
        chk("t5_addr", {59'd0, addr1}, 64'd31);
        chk("t5_cs", {63'd0, cs1}, 64'd1);
`ifndef IFETCH_HALT_ON_WRAP_EN
        for (int i = 0; i < 20 && (exp_q1.size() > 0 || v1); i++) begin
            if (v1 && exp_q1.size() == 1) run1 = 0;
            step();
        end
        chk("t5_drain", 64'(exp_q1.size()), 64'd0);
        chk("t5_xfers", 64'(xfers1), 64'd6);
        chk("t5_halted", {63'd0, h1}, 64'd0);
        chk("t5_idle_cs", {63'd0, cs1}, 64'd0);
`else
        step();
        step();
        chk("t5_halted", {63'd0, h1}, 64'd1);
        chk("t5_halt_cs", {63'd0, cs1}, 64'd0);
        chk("t5_halt_valid", {63'd0, v1}, 64'd0);
        chk("t5_halt_pc", {59'd0, addr1}, 64'd0);
        step();
        chk("t5_halt_hold", {63'd0, h1}, 64'd1);
        chk("t5_halt_cs2", {63'd0, cs1}, 64'd0);
        ld1 = 1; lv1 = 5'd5;
        exp_q1.push_back({5'd5, rom_word(5'd5)});
        step();
        ld1 = 0; run1 = 0;
        chk("t5_resume_cs", {63'd0, cs1}, 64'd1);
        chk("t5_resume_h", {63'd0, h1}, 64'd0);
        step();
        step();
        chk("t5_drain", 64'(exp_q1.size()), 64'd0);
        chk("t5_xfers", 64'(xfers1), 64'd5);
`endif

        // Redirect mid-fetch with a three-cycle settle.
        run3 = 1; rdy3 = 1;
        step();
        chk("t4_cs_c1", {63'd0, cs3}, 64'd1);
        step();
        chk("t4_cs_c2", {63'd0, cs3}, 64'd1);
        chk("t4_novalid", {63'd0, v3}, 64'd0);
        ld3 = 1; lv3 = 5'd7;
        exp_q3.push_back({5'd7, rom_word(5'd7)});
        step();
        ld3 = 0; run3 = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_cs", {63'd0, cs3}, 64'd1);
            chk("t4_addr", {59'd0, addr3}, 64'd7);
            chk("t4_wait", {63'd0, v3}, 64'd0);
            step();
        end
        chk("t4_valid", {63'd0, v3}, 64'd1);
        chk("t4_ipc", {59'd0, ipc3}, 64'd7);
        chk("t4_instr", {32'd0, instr3}, {32'd0, rom_word(5'd7)});
        chk("t4_cs_off", {63'd0, cs3}, 64'd0);
        step();
        chk("t4_xfers", 64'(xfers3), 64'd1);
        chk("t4_idle_cs", {63'd0, cs3}, 64'd0);

        // Asynchronous reset between edges while fetching.
        run1 = 1; rdy1 = 1;
        step();
        chk("t6_pre_cs", {63'd0, cs1}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_cs", {63'd0, cs1}, 64'd0);
        chk("t6_valid", {63'd0, v1}, 64'd0);
        chk("t6_halted", {63'd0, h1}, 64'd0);
        chk("t6_pc", {59'd0, addr1}, 64'd0);
        run1 = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        chk("t6_post_cs", {63'd0, cs1}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
